// File: rtl/i2c_slave_regs.sv
// I2C target exposing four 16-bit registers behind an auto-incrementing pointer.
// A local host write port shares the registers and wins over a same-cycle bus commit.
module i2c_slave_regs #(
    parameter logic [6:0]  DEV_ADDR = 7'b1001000,
    parameter logic [15:0] RST0     = 16'h1111,
    parameter logic [15:0] RST1     = 16'h2222,
    parameter logic [15:0] RST2     = 16'h3333,
    parameter logic [15:0] RST3     = 16'h4444
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl,
    inout  wire         sda,
    input  logic        host_we,
    input  logic [1:0]  host_idx,
    input  logic [15:0] host_wdata,
    output logic        wr_pulse,
    output logic [1:0]  wr_idx,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic [1:0]  ptr
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_MACK, WAIT_STOP
    } state_t;

    state_t      state, state_n;
    logic        scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shift, shift_n, msb, msb_n, rd_byte;
    logic        have_msb, have_msb_n, rw, rw_n, rd_lsb, rd_lsb_n, mack, mack_n;
    logic [15:0] rd_word, rd_word_n, wr_data_n;
    logic        sda_low, sda_low_n, busy_n, commit;
    logic [1:0]  ptr_n, ptr_inc, wr_idx_n;
    logic [15:0] regs [4];

    assign sda = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign ptr_inc   = ptr + 2'd1;
    assign rd_byte   = rd_lsb ? rd_word[7:0] : rd_word[15:8];

    // bit_cnt counts 7..0 on scl rises; bit 3 set means the byte is complete.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        msb_n      = msb;
        have_msb_n = have_msb;
        rw_n       = rw;
        rd_word_n  = rd_word;
        rd_lsb_n   = rd_lsb;
        mack_n     = mack;
        sda_low_n  = sda_low;
        busy_n     = busy;
        ptr_n      = ptr;
        commit     = 1'b0;
        wr_idx_n   = wr_idx;
        wr_data_n  = wr_data;
        if (start_det) begin
            state_n    = ADDR;
            bit_cnt_n  = 4'd7;
            sda_low_n  = 1'b0;
            busy_n     = 1'b0;
            have_msb_n = 1'b0;
        end else if (stop_det) begin
            state_n    = IDLE;
            sda_low_n  = 1'b0;
            busy_n     = 1'b0;
            have_msb_n = 1'b0;
        end else begin
            if (scl_rise && !bit_cnt[3] && (state inside {ADDR, PTR, WR_BYTE, RD_BYTE})) begin
                shift_n   = {shift[6:0], sda_s2};
                bit_cnt_n = bit_cnt - 4'd1;
            end
            case (state)
                ADDR: if (scl_fall && bit_cnt[3]) begin
                    if (shift[7:1] == DEV_ADDR) begin
                        state_n   = ADDR_ACK;
                        sda_low_n = 1'b1;
                        busy_n    = 1'b1;
                        rw_n      = shift[0];
                    end else begin
                        state_n   = IDLE;
                        sda_low_n = 1'b0;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    bit_cnt_n = 4'd7;
                    if (rw) begin
                        state_n   = RD_BYTE;
                        rd_word_n = regs[ptr];
                        rd_lsb_n  = 1'b0;
                        sda_low_n = ~regs[ptr][15];
                    end else begin
                        state_n   = PTR;
                        sda_low_n = 1'b0;
                    end
                end
                PTR: if (scl_fall && bit_cnt[3]) begin
                    state_n   = PTR_ACK;
                    sda_low_n = 1'b1;
                    ptr_n     = shift[1:0];
                end
                PTR_ACK, WR_ACK: if (scl_fall) begin
                    state_n    = WR_BYTE;
                    bit_cnt_n  = 4'd7;
                    sda_low_n  = 1'b0;
                    have_msb_n = (state == WR_ACK) ? have_msb : 1'b0;
                end
                WR_BYTE: if (scl_fall && bit_cnt[3]) begin
                    state_n   = WR_ACK;
                    sda_low_n = 1'b1;
                    if (have_msb) begin
                        commit     = 1'b1;
                        wr_idx_n   = ptr;
                        wr_data_n  = {msb, shift};
                        ptr_n      = ptr_inc;
                        have_msb_n = 1'b0;
                    end else begin
                        msb_n      = shift;
                        have_msb_n = 1'b1;
                    end
                end
                RD_BYTE: if (scl_fall) begin
                    if (bit_cnt[3]) begin
                        state_n   = RD_MACK;
                        sda_low_n = 1'b0;
                    end else begin
                        sda_low_n = ~rd_byte[bit_cnt[2:0]];
                    end
                end
                RD_MACK: begin
                    if (scl_rise) begin
                        mack_n = ~sda_s2;
                    end else if (scl_fall) begin
                        if (mack) begin
                            state_n   = RD_BYTE;
                            bit_cnt_n = 4'd7;
                            if (rd_lsb) begin
                                ptr_n     = ptr_inc;
                                rd_word_n = regs[ptr_inc];
                                rd_lsb_n  = 1'b0;
                                sda_low_n = ~regs[ptr_inc][15];
                            end else begin
                                rd_lsb_n  = 1'b1;
                                sda_low_n = ~rd_word[7];
                            end
                        end else begin
                            state_n   = WAIT_STOP;
                            sda_low_n = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= 4'd7;
            shift    <= 8'h00;
            msb      <= 8'h00;
            have_msb <= 1'b0;
            rw       <= 1'b0;
            rd_word  <= 16'h0000;
            rd_lsb   <= 1'b0;
            mack     <= 1'b0;
            sda_low  <= 1'b0;
            busy     <= 1'b0;
            ptr      <= 2'd0;
            wr_pulse <= 1'b0;
            wr_idx   <= 2'd0;
            wr_data  <= 16'h0000;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            msb      <= msb_n;
            have_msb <= have_msb_n;
            rw       <= rw_n;
            rd_word  <= rd_word_n;
            rd_lsb   <= rd_lsb_n;
            mack     <= mack_n;
            sda_low  <= sda_low_n;
            busy     <= busy_n;
            ptr      <= ptr_n;
            wr_pulse <= commit;
            wr_idx   <= wr_idx_n;
            wr_data  <= wr_data_n;
        end
    end

    // The host write is placed last so it overrides a bus commit to the same index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs[0] <= RST0;
            regs[1] <= RST1;
            regs[2] <= RST2;
            regs[3] <= RST3;
        end else begin
            if (commit) regs[ptr] <= {msb, shift};
            if (host_we) regs[host_idx] <= host_wdata;
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged I2C master plus a table of
// word writes that are read back over the bus.
`timescale 1ns/1ps
module tb_i2c_slave_regs;

    localparam int Q = 8;

    typedef struct {
        logic [1:0]  idx;
        logic [15:0] word;
        logic [1:0]  exp_wr_idx;
        logic [1:0]  exp_ptr;
        logic [1:0]  exp_rd_ptr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, scl, m_sda_low, host_we;
    logic [1:0]  host_idx;
    logic [15:0] host_wdata;
    wire         sda;
    logic        wr_pulse, busy;
    logic [1:0]  wr_idx, ptr;
    logic [15:0] wr_data;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   pulse_cnt = 0;
    logic mon_en = 1'b0;
    logic dut_drove = 1'b0;
    logic busy_seen = 1'b0;

    always #5 clk = ~clk;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave_regs dut (
        .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
        .host_we(host_we), .host_idx(host_idx), .host_wdata(host_wdata),
        .wr_pulse(wr_pulse), .wr_idx(wr_idx), .wr_data(wr_data),
        .busy(busy), .ptr(ptr)
    );

    // Counts high cycles of wr_pulse and watches for illegal driving while enabled.
    always @(negedge clk) begin
        if (wr_pulse) pulse_cnt <= pulse_cnt + 1;
        if (!mon_en) begin
            dut_drove <= 1'b0;
            busy_seen <= 1'b0;
        end else begin
            if (!m_sda_low && sda == 1'b0) dut_drove <= 1'b1;
            if (busy) busy_seen <= 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_output(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; tick(Q);
        scl = 1'b1;       tick(Q);
        m_sda_low = 1'b1; tick(Q);
        scl = 1'b0;       tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; tick(Q);
        scl = 1'b1;       tick(Q);
        m_sda_low = 1'b0; tick(Q);
    endtask

    task automatic send_bit(input logic b, input logic collide);
        m_sda_low = ~b; tick(Q);
        scl = 1'b1;     tick(2 * Q);
        scl = 1'b0;
        if (collide) begin
            tick(2);
            host_we = 1'b1;
            tick(1);
            host_we = 1'b0;
            tick(Q - 3);
        end else begin
            tick(Q);
        end
    endtask

    task automatic recv_bit(output logic b);
        m_sda_low = 1'b0; tick(Q);
        scl = 1'b1;       tick(Q);
        b = sda;          tick(Q);
        scl = 1'b0;       tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic collide, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i], collide && (i == 0));
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~mack, 1'b0);
    endtask

    task automatic write_word(input logic [1:0] idx, input logic [15:0] w,
                              input logic collide, output int acks);
        logic a;
        acks = 0;
        i2c_start();
        write_byte(8'h90, 1'b0, a);          acks += int'(a);
        write_byte({6'd0, idx}, 1'b0, a);    acks += int'(a);
        write_byte(w[15:8], 1'b0, a);        acks += int'(a);
        write_byte(w[7:0], collide, a);      acks += int'(a);
        i2c_stop();
    endtask

    task automatic read_word(input logic [1:0] idx, output logic [15:0] w, output int acks);
        logic a;
        logic [7:0] hi, lo;
        acks = 0;
        i2c_start();
        write_byte(8'h90, 1'b0, a);          acks += int'(a);
        write_byte({6'd0, idx}, 1'b0, a);    acks += int'(a);
        i2c_start();
        write_byte(8'h91, 1'b0, a);          acks += int'(a);
        read_byte(1'b1, hi);
        read_byte(1'b0, lo);
        i2c_stop();
        w = {hi, lo};
    endtask

    task automatic apply_stimulus(input vec_t v);
        int acks, p0;
        logic [15:0] rd;
        p0 = pulse_cnt;
        write_word(v.idx, v.word, 1'b0, acks);
        tick(2);
        check_output("vec write acks", acks, 4);
        check_output("vec pulse count", pulse_cnt - p0, 1);
        check_output("vec wr_idx", int'(wr_idx), int'(v.exp_wr_idx));
        check_output("vec wr_data", int'(wr_data), int'(v.word));
        check_output("vec ptr after write", int'(ptr), int'(v.exp_ptr));
        read_word(v.idx, rd, acks);
        tick(2);
        check_output("vec readback acks", acks, 3);
        check_output("vec readback", int'(rd), int'(v.word));
        check_output("vec ptr after read", int'(ptr), int'(v.exp_rd_ptr));
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[4];
        logic a;
        logic b0, b1;
        logic [7:0] d0, d1, d2, d3;
        logic [15:0] w;
        int acks, p0;

        vecs[0] = '{idx: 2'd1, word: 16'hA5C3, exp_wr_idx: 2'd1, exp_ptr: 2'd2, exp_rd_ptr: 2'd1};
        vecs[1] = '{idx: 2'd3, word: 16'h0001, exp_wr_idx: 2'd3, exp_ptr: 2'd0, exp_rd_ptr: 2'd3};
        vecs[2] = '{idx: 2'd0, word: 16'hFFFF, exp_wr_idx: 2'd0, exp_ptr: 2'd1, exp_rd_ptr: 2'd0};
        vecs[3] = '{idx: 2'd2, word: 16'h8000, exp_wr_idx: 2'd2, exp_ptr: 2'd3, exp_rd_ptr: 2'd2};

        rst_n = 1'b0; scl = 1'b1; m_sda_low = 1'b0;
        host_we = 1'b0; host_idx = 2'd0; host_wdata = 16'h0000;
        tick(4);
        check_output("reset busy", int'(busy), 0);
        check_output("reset ptr", int'(ptr), 0);
        check_output("reset wr_pulse", int'(wr_pulse), 0);
        check_output("reset wr_idx", int'(wr_idx), 0);
        check_output("reset wr_data", int'(wr_data), 0);
        check_output("reset sda released", int'(sda), 1);
        rst_n = 1'b1;
        tick(4);

        // Read with no pointer write: reg0 then reg1 via auto-increment.
        i2c_start();
        write_byte(8'h91, 1'b0, a);
        check_output("plain read addr ack", int'(a), 1);
        read_byte(1'b1, d0); read_byte(1'b1, d1);
        read_byte(1'b1, d2); read_byte(1'b0, d3);
        i2c_stop();
        check_output("plain read reg0", int'({d0, d1}), 16'h1111);
        check_output("plain read reg1", int'({d2, d3}), 16'h2222);
        check_output("plain read ptr", int'(ptr), 1);

        // Partial word ended by STOP, then by repeated START.
        p0 = pulse_cnt;
        i2c_start();
        write_byte(8'h90, 1'b0, a); write_byte(8'h00, 1'b0, a); write_byte(8'hAA, 1'b0, a);
        check_output("partial msb ack", int'(a), 1);
        i2c_stop();
        i2c_start();
        write_byte(8'h90, 1'b0, a); write_byte(8'h00, 1'b0, a); write_byte(8'hAA, 1'b0, a);
        i2c_start();
        write_byte(8'h91, 1'b0, a);
        read_byte(1'b1, d0); read_byte(1'b0, d1);
        i2c_stop();
        tick(2);
        check_output("partial no pulse", pulse_cnt - p0, 0);
        check_output("partial reg0 kept", int'({d0, d1}), 16'h1111);
        check_output("partial ptr", int'(ptr), 0);

        // Pointer write, repeated START, read ACK then NACK.
        i2c_start();
        write_byte(8'h90, 1'b0, a); write_byte(8'h01, 1'b0, a);
        i2c_start();
        write_byte(8'h91, 1'b0, a);
        check_output("busy mid transfer", int'(busy), 1);
        read_byte(1'b1, d0); read_byte(1'b0, d1);
        i2c_stop();
        tick(2);
        check_output("rstart read msb", int'(d0), 8'h22);
        check_output("rstart read lsb", int'(d1), 8'h22);
        check_output("rstart read ptr", int'(ptr), 1);
        check_output("busy after stop", int'(busy), 0);

        // Basic write of 0xBEEF to reg2.
        p0 = pulse_cnt;
        write_word(2'd2, 16'hBEEF, 1'b0, acks);
        tick(2);
        check_output("beef acks", acks, 4);
        check_output("beef pulse count", pulse_cnt - p0, 1);
        check_output("beef wr_idx", int'(wr_idx), 2);
        check_output("beef wr_data", int'(wr_data), 16'hBEEF);
        check_output("beef ptr", int'(ptr), 3);

        // Two words from pointer 3 wrap to reg0.
        p0 = pulse_cnt;
        acks = 0;
        i2c_start();
        write_byte(8'h90, 1'b0, a); acks += int'(a);
        write_byte(8'h03, 1'b0, a); acks += int'(a);
        write_byte(8'h12, 1'b0, a); acks += int'(a);
        write_byte(8'h34, 1'b0, a); acks += int'(a);
        write_byte(8'h56, 1'b0, a); acks += int'(a);
        write_byte(8'h78, 1'b0, a); acks += int'(a);
        i2c_stop();
        tick(2);
        check_output("wrap acks", acks, 6);
        check_output("wrap pulse count", pulse_cnt - p0, 2);
        check_output("wrap last wr_idx", int'(wr_idx), 0);
        check_output("wrap last wr_data", int'(wr_data), 16'h5678);
        check_output("wrap ptr", int'(ptr), 1);
        i2c_start();
        write_byte(8'h90, 1'b0, a); write_byte(8'h03, 1'b0, a);
        i2c_start();
        write_byte(8'h91, 1'b0, a);
        read_byte(1'b1, d0); read_byte(1'b1, d1);
        read_byte(1'b1, d2); read_byte(1'b0, d3);
        i2c_stop();
        check_output("wrap reg3", int'({d0, d1}), 16'h1234);
        check_output("wrap reg0", int'({d2, d3}), 16'h5678);
        check_output("wrap read ptr", int'(ptr), 0);

        // Foreign address must be ignored; a following valid access still works.
        mon_en = 1'b1;
        tick(1);
        i2c_start();
        write_byte(8'hA0, 1'b0, a);
        tick(2);
        check_output("mismatch no ack", int'(a), 0);
        check_output("mismatch sda never low", int'(dut_drove), 0);
        check_output("mismatch busy stays low", int'(busy_seen), 0);
        mon_en = 1'b0;
        i2c_start();
        write_byte(8'h90, 1'b0, a);
        check_output("after mismatch addr ack", int'(a), 1);
        write_byte(8'h01, 1'b0, a);
        i2c_stop();
        check_output("after mismatch ptr", int'(ptr), 1);

        for (int i = 0; i < 4; i++) apply_stimulus(vecs[i]);

        // Host write alone must not pulse wr_pulse.
        p0 = pulse_cnt;
        host_idx = 2'd1; host_wdata = 16'h4321; host_we = 1'b1;
        tick(1);
        host_we = 1'b0;
        tick(2);
        check_output("host write no pulse", pulse_cnt - p0, 0);
        read_word(2'd1, w, acks);
        check_output("host write readback", int'(w), 16'h4321);

        // Host write and bus commit to reg2 in the same clock: host data wins.
        p0 = pulse_cnt;
        host_idx = 2'd2; host_wdata = 16'h0F0F;
        write_word(2'd2, 16'hBEEF, 1'b1, acks);
        tick(2);
        check_output("collide pulse count", pulse_cnt - p0, 1);
        check_output("collide wr_idx", int'(wr_idx), 2);
        check_output("collide wr_data", int'(wr_data), 16'hBEEF);
        read_word(2'd2, w, acks);
        check_output("collide reg2", int'(w), 16'h0F0F);

        // Reset while reg2 (0x0F0F) is being shifted out with a 0 bit on the bus.
        p0 = pulse_cnt;
        i2c_start();
        write_byte(8'h90, 1'b0, a); write_byte(8'h02, 1'b0, a);
        i2c_start();
        write_byte(8'h91, 1'b0, a);
        recv_bit(b0); recv_bit(b1);
        check_output("abort first bits", int'({b0, b1}), 0);
        check_output("abort sda driven", int'(sda), 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_output("abort sda released", int'(sda), 1);
        check_output("abort ptr", int'(ptr), 0);
        check_output("abort busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(4);
        i2c_stop();
        i2c_start();
        write_byte(8'h91, 1'b0, a);
        read_byte(1'b1, d0); read_byte(1'b0, d1);
        i2c_stop();
        tick(2);
        check_output("post reset reg0", int'({d0, d1}), 16'h1111);
        check_output("abort no pulse", pulse_cnt - p0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regs.md
I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'b1001000, meaning the 7-bit target address it responds to.
REQ-002 The block SHALL have parameter RST0..RST3, defaults 16'h1111, 16'h2222, 16'h3333, 16'h4444, meaning the register reset values.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, all logic on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port scl, input, 1 bit: I2C clock; the block never drives it and never stretches.
REQ-006 The block SHALL have port sda, inout, 1 bit: I2C data, open-drain; it is driven 0 or released to z.
REQ-007 The block SHALL have ports host_we (input, 1 bit), host_idx (input, 2 bits) and host_wdata (input, 16 bits): local register write port.
REQ-008 The block SHALL have ports wr_pulse (output, 1 bit), wr_idx (output, 2 bits) and wr_data (output, 16 bits): one-clk notification of a word committed over I2C.
REQ-009 The block SHALL have port busy, output, 1 bit: high from address ACK until STOP, START or address-mismatch return to IDLE.
REQ-010 The block SHALL have port ptr, output, 2 bits: current register pointer.

Function
REQ-011 scl and sda SHALL pass through 2-FF synchronizers; all edges SHALL be detected on the synchronized copies.
REQ-012 START (sda fall with scl high) SHALL be recognized in any state, including repeated START, and SHALL enter ADDR with bit count 7.
REQ-013 STOP (sda rise with scl high) SHALL be recognized in any state, SHALL release sda and enter IDLE.
REQ-014 Data SHALL be sampled on the synchronized scl rising edge, MSB first.
REQ-015 Driven sda SHALL change only on the synchronized scl falling edge and SHALL be held until the next falling edge.
REQ-016 The states SHALL be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_MACK and WAIT_STOP.
REQ-017 On address match in ADDR, the block SHALL drive ACK (sda=0) for the 9th clock; R/W=0 SHALL go to PTR and R/W=1 SHALL go to RD_BYTE.
REQ-018 On address mismatch, the block SHALL NOT ACK, SHALL release sda and SHALL wait in IDLE for the next START.
REQ-019 In PTR, the block SHALL always ACK; ptr SHALL load byte[1:0] and bits [7:2] SHALL be ignored; the next state SHALL be WR_BYTE with the MSB expected.
REQ-020 Writes: the first data byte SHALL be held as MSB and the second as LSB; each byte SHALL be ACKed.
REQ-021 The word {MSB,LSB} SHALL be written to reg[ptr], with wr_pulse=1 for exactly one clk, wr_idx=ptr and wr_data=word, in the clk after the scl falling edge that starts the LSB ACK.
REQ-022 After a commit, ptr SHALL increment modulo 4 (3 wraps to 0); further byte pairs SHALL write successive registers.
REQ-023 A partial word (MSB then STOP or START) SHALL be discarded: no commit, no wr_pulse, ptr unchanged.
REQ-024 Reads: the block SHALL shift out reg[ptr][15:8] then reg[ptr][7:0], releasing sda during each master-ACK clock.
REQ-025 After the LSB, a master ACK SHALL increment ptr modulo 4 and continue with the next register's MSB.
REQ-026 A master NACK after any read byte SHALL release sda and go to WAIT_STOP.
REQ-027 A read without a preceding pointer write SHALL use the current ptr (0 after reset).
REQ-028 The read word SHALL be latched when its MSB begins; a host write during the shift SHALL NOT alter bits in flight.
REQ-029 host_we SHALL write reg[host_idx]=host_wdata in the same clk and SHALL NOT assert wr_pulse.
REQ-030 If host_we and an I2C commit target the same index in the same clk, host_wdata SHALL win; wr_pulse SHALL still fire with the I2C data.

Reset
REQ-031 While rst_n=0 at a clk edge: sda SHALL be released; state SHALL be IDLE; ptr=0, busy=0, wr_pulse=0, wr_idx=0, wr_data=0; regs SHALL equal RST0..RST3; synchronizers SHALL be set to 1.
REQ-032 Reset mid-transfer SHALL abort without commit; after reset the block SHALL ignore the bus until a new START.

Verification
REQ-033 Write: START, 0x90, 0x02, 0xBE, 0xEF, STOP -> four ACKs; wr_pulse once with wr_idx=2, wr_data=0xBEEF; ptr=3.
REQ-034 Read: START, 0x90, 0x01, repeated START, 0x91, read 2 bytes (ACK, NACK), STOP -> bytes 0x22, 0x22; ptr=1 after NACK.
REQ-035 Wrap: pointer 3, write 0x1234 then 0x5678 in one transaction -> reg3=0x1234, reg0=0x5678; ptr=1; two wr_pulses.
REQ-036 Mismatch: START, 0xA0 -> sda never driven low; busy stays 0; the next valid transaction succeeds.
REQ-037 Partial and abort: 0x90, 0x00, 0xAA, STOP -> no wr_pulse, reg0=0x1111; reset asserted during a read byte -> sda released within 1 clk, ptr=0.
REQ-038 Collision: host_we to idx 2 with 0x0F0F in the same clk as an I2C commit of 0xBEEF to idx 2 -> reg2=0x0F0F; wr_data=0xBEEF.
